// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are halfword aligned; the low address bit is never honoured.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port, execute redirect and decode handoff.
interface fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer of {pc, instr}; push and pop may coincide at any occupancy.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t entries [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign head  = entries[rd_ptr];

    // Storage and pointers; flush discards contents but keeps stale data harmlessly.
    always_ff @(posedge clock) begin
        if (reset) begin
            entries[0] <= '0;
            entries[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= wr_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, prefetches into a 2-entry FIFO,
// applies execute redirects and stops on the halt sentinel or an illegal PC.
//
//   state  | meaning
//   IDLE   | after reset, no fetch until start
//   RUN    | fetching one word per cycle while the FIFO has room
//   DRAIN  | fetch stopped, waiting for decode to empty the FIFO
//   HALTED | fetch finished; start restarts, redirects ignored
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
    parameter int                 MEM_WORDS = 1024,
    parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    fetch_if.master           bus,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] fetch_count
);

    // One bit wider than the PC so 2*MEM_WORDS = 65536 would still compare correctly.
    localparam logic [ADDR_W:0] PC_LIMIT = (ADDR_W + 1)'(2 * MEM_WORDS);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              fault_nxt;
    logic              push, flush, count_clr, count_inc;
    logic              pop, can_fetch, in_range;
    logic              fifo_full, fifo_empty;
    fetch_entry_t      head;

    assign pop       = bus.out_valid & bus.out_ready;
    assign can_fetch = ~fifo_full | pop;
    assign in_range  = ({1'b0, pc} < PC_LIMIT);

    fetch_fifo u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data ('{pc: pc, instr: bus.imem_data}),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.imem_addr = pc;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign halted        = (state == HALTED);

    // Next-state, PC and FIFO control; redirect outranks enqueue and halt detection.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        fault_nxt = fault;
        push      = 1'b0;
        flush     = 1'b0;
        count_clr = 1'b0;
        count_inc = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = RESET_PC;
                    fault_nxt = 1'b0;
                    count_clr = 1'b1;
                end
            end
            RUN: begin
                if (bus.redirect_valid) begin
                    flush     = 1'b1;
                    pc_nxt    = align_pc(bus.redirect_addr);
                    fault_nxt = 1'b0;
                end else if (can_fetch) begin
                    if (!in_range) begin
                        fault_nxt = 1'b1;
                        state_nxt = DRAIN;
                    end else if (bus.imem_data == HALT_WORD) begin
                        state_nxt = DRAIN;
                    end else begin
                        push      = 1'b1;
                        pc_nxt    = pc + 16'd2;
                        count_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // The sentinel may have been fetched past a taken branch, so a redirect revives fetch.
                if (bus.redirect_valid) begin
                    flush     = 1'b1;
                    pc_nxt    = align_pc(bus.redirect_addr);
                    fault_nxt = 1'b0;
                    state_nxt = RUN;
                end else if (fifo_empty) begin
                    state_nxt = HALTED;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, PC, sticky fault and saturating fetch counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            fault <= fault_nxt;
            if (count_clr) begin
                fetch_count <= '0;
            end else if (count_inc && (fetch_count != 16'hFFFF)) begin
                fetch_count <= fetch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural stream model fills the
// expected queue on start/redirect, an independent monitor checks every pop.
module tb_fetch_sequencer;

    localparam int MEMW = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    fetch_if fif();

    logic [15:0] mem [MEMW];
    logic [31:0] exp_q [$];
    int          exp_len;
    bit          exp_fault;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    fetch_sequencer #(
        .RESET_PC  (16'h0000),
        .MEM_WORDS (MEMW),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .bus         (fif.master),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    // Combinational instruction memory; addresses past the end read filler.
    always_comb begin
        fif.imem_data = 16'h0BAD;
        if (fif.imem_addr < 16'(2 * MEMW)) fif.imem_data = mem[fif.imem_addr[4:1]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the PC from the fetch origin until the sentinel or the end of memory.
    task automatic load_stream(input logic [15:0] from_pc);
        logic [15:0] p;
        p = from_pc & 16'hFFFE;
        exp_q.delete();
        exp_len   = 0;
        exp_fault = 1'b0;
        for (int k = 0; k < 70000; k++) begin
            if (int'(p) >= 2 * MEMW) begin
                exp_fault = 1'b1;
                break;
            end
            if (mem[p[4:1]] == 16'hFFFF) break;
            exp_q.push_back({p, mem[p[4:1]]});
            exp_len++;
            p = p + 16'd2;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        load_stream(16'h0000);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_redirect(input logic [15:0] addr);
        fif.redirect_valid = 1'b1;
        fif.redirect_addr  = addr;
        step();
        fif.redirect_valid = 1'b0;
        load_stream(addr);
    endtask

    task automatic wait_halted(input int budget);
        int c;
        c = 0;
        while (halted !== 1'b1 && c < budget) begin
            step();
            c++;
        end
        chk("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    task automatic end_check(input string name, input bit check_count, input int count_exp);
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_fault"}, {31'd0, fault}, {31'd0, exp_fault});
        if (check_count) chk({name, "_count"}, {16'd0, fetch_count}, count_exp);
    endtask

    // Monitor: every accepted head must match the next expected {pc, instr}.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (fif.out_valid === 1'b1 && fif.out_ready === 1'b1 && reset === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got pc %h instr %h expected no output",
                             fif.out_pc, fif.out_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_entry", {fif.out_pc, fif.out_instr}, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nred;
        int c;
        reset              = 1'b1;
        start              = 1'b0;
        fif.out_ready      = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.redirect_addr  = 16'h0000;
        mem[0] = 16'h710F; mem[1] = 16'h7207; mem[2] = 16'h26C0; mem[3] = 16'h2A41;
        mem[4] = 16'h8C02; mem[5] = 16'h0F13; mem[6] = 16'h4E24; mem[7] = 16'h6B35;
        mem[8] = 16'h1D46; mem[9] = 16'hFFFF;
        for (int i = 10; i < MEMW; i++) mem[i] = 16'h3000 + 16'(i);
        step();
        step();

        chk("rst_out_valid", {31'd0, fif.out_valid}, 0);
        chk("rst_out_instr", {16'd0, fif.out_instr}, 0);
        chk("rst_out_pc", {16'd0, fif.out_pc}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_fault", {31'd0, fault}, 0);
        chk("rst_count", {16'd0, fetch_count}, 0);
        chk("rst_imem_addr", {16'd0, fif.imem_addr}, 0);
        reset = 1'b0;
        step();
        chk("idle_no_fetch", {16'd0, fif.imem_addr}, 0);

        // Sequential fetch with decode always ready.
        fif.out_ready = 1'b1;
        do_start();
        chk("seq_addr_n1", {16'd0, fif.imem_addr}, 0);
        chk("seq_valid_n1", {31'd0, fif.out_valid}, 0);
        step();
        chk("seq_valid_n2", {31'd0, fif.out_valid}, 1);
        chk("seq_pc_n2", {16'd0, fif.out_pc}, 0);
        wait_halted(40);
        end_check("seq", 1'b1, 9);

        // Backpressure: decode stalled for five cycles after start.
        fif.out_ready = 1'b0;
        do_start();
        repeat (4) step();
        chk("bp_instr", {16'd0, fif.out_instr}, 32'h710F);
        chk("bp_pc", {16'd0, fif.out_pc}, 0);
        chk("bp_imem_addr", {16'd0, fif.imem_addr}, 32'h0004);
        fif.out_ready = 1'b1;
        wait_halted(40);
        end_check("bp", 1'b1, 9);

        // Redirect to an odd address with two entries buffered.
        fif.out_ready = 1'b0;
        do_start();
        step();
        step();
        chk("rd_full_addr", {16'd0, fif.imem_addr}, 32'h0004);
        do_redirect(16'h000D);
        chk("rd_flushed", {31'd0, fif.out_valid}, 0);
        chk("rd_imem_addr", {16'd0, fif.imem_addr}, 32'h000C);
        fif.out_ready = 1'b1;
        step();
        chk("rd_valid", {31'd0, fif.out_valid}, 1);
        chk("rd_out_pc", {16'd0, fif.out_pc}, 32'h000C);
        wait_halted(40);
        end_check("rd", 1'b1, 2 + exp_len);

        // Halt cancel: sentinel at word 3, redirect back to 0 during DRAIN.
        mem[3] = 16'hFFFF;
        fif.out_ready = 1'b0;
        do_start();
        step();
        step();
        fif.out_ready = 1'b1;
        step();
        step();
        fif.out_ready = 1'b0;
        chk("hc_drain_halted", {31'd0, halted}, 0);
        chk("hc_drain_addr", {16'd0, fif.imem_addr}, 32'h0006);
        chk("hc_drain_pc", {16'd0, fif.out_pc}, 32'h0004);
        do_redirect(16'h0000);
        chk("hc_halted", {31'd0, halted}, 0);
        chk("hc_addr", {16'd0, fif.imem_addr}, 0);
        chk("hc_flushed", {31'd0, fif.out_valid}, 0);
        fif.out_ready = 1'b1;
        step();
        chk("hc_restart_pc", {16'd0, fif.out_pc}, 0);
        chk("hc_restart_valid", {31'd0, fif.out_valid}, 1);
        wait_halted(40);
        end_check("hc", 1'b1, 3 + exp_len);

        // Out of range: no sentinel anywhere, fetch runs off the end of memory.
        for (int i = 0; i < MEMW; i++) mem[i] = 16'h5000 + 16'(i * 17);
        fif.out_ready = 1'b1;
        do_start();
        wait_halted(60);
        end_check("oor", 1'b1, MEMW);
        chk("oor_stop_addr", {16'd0, fif.imem_addr}, 2 * MEMW);
        do_start();
        chk("oor_fault_clear", {31'd0, fault}, 0);
        chk("oor_refetch_addr", {16'd0, fif.imem_addr}, 0);
        wait_halted(60);
        end_check("oor2", 1'b1, MEMW);

        // Reset with two entries buffered.
        fif.out_ready = 1'b0;
        do_start();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("mr_valid", {31'd0, fif.out_valid}, 0);
        chk("mr_halted", {31'd0, halted}, 0);
        chk("mr_count", {16'd0, fetch_count}, 0);
        chk("mr_addr", {16'd0, fif.imem_addr}, 0);
        chk("mr_fault", {31'd0, fault}, 0);
        repeat (3) step();
        chk("mr_idle_addr", {16'd0, fif.imem_addr}, 0);
        chk("mr_idle_valid", {31'd0, fif.out_valid}, 0);

        // Randomized runs with random memory, stalls and redirects.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < MEMW; i++)
                mem[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            fif.out_ready = ($urandom_range(0, 3) != 0);
            do_start();
            nred = 0;
            c = 0;
            while (halted !== 1'b1 && c < 400) begin
                fif.out_ready = ($urandom_range(0, 3) != 0);
                if (nred < 3 && $urandom_range(0, 29) == 0) begin
                    do_redirect(16'($urandom_range(0, 2 * MEMW + 4)));
                    nred++;
                end else begin
                    step();
                end
                c++;
            end
            chk("rand_halt", {31'd0, halted}, 1);
            end_check("rand", (nred == 0), exp_len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 16-bit simplified MIPS core. It sits between the combinational instruction memory and the decode stage.
- Owns the PC and drives the memory address each cycle.
- Buffers fetched words in a 2-entry prefetch FIFO with valid/ready handoff to decode.
- Applies redirects from execute and stops fetch on the 16'hFFFF halt sentinel or an out-of-range PC.

Parameters:
- RESET_PC, 16'h0000, byte address loaded on start.
- MEM_WORDS, 1024, instruction memory depth in 16-bit words; legal PCs are 0 .. 2*MEM_WORDS-2.
- HALT_WORD, 16'hFFFF, sentinel instruction that ends fetch.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins fetching at RESET_PC; honoured only in IDLE or HALTED.
- imem_addr  out  16  byte address to instruction memory; memory reads word imem_addr>>1 combinationally.
- imem_data  in  16  instruction word returned the same cycle.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_addr  in  16  new byte PC; bit 0 forced to 0.
- out_valid  out  1  FIFO head valid.
- out_instr  out  16  FIFO head instruction.
- out_pc  out  16  byte PC of the head instruction.
- out_ready  in  1  decode accepts the head this cycle.
- halted  out  1  high in HALTED state.
- fault  out  1  sticky; set when fetch stopped on an out-of-range PC.
- fetch_count  out  16  instructions enqueued since start, saturating at 16'hFFFF.

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, FIFO empty.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, fetch_count=0.
  - imem_addr=pc.
- Reset has priority over every other input.
- States:
  - IDLE: no fetch. start → RUN, pc=RESET_PC, fetch_count=0, fault=0.
  - RUN: every cycle, fetch is allowed when the FIFO is not full, or when it is full and a pop occurs the same cycle.
    - If imem_data != HALT_WORD: enqueue {pc, imem_data}, pc += 2, fetch_count += 1 (saturating).
    - If imem_data == HALT_WORD: nothing enqueued, pc holds, → DRAIN.
    - If pc >= 2*MEM_WORDS: nothing enqueued, fault=1, → DRAIN. The range check has priority over the HALT_WORD compare.
  - DRAIN: no fetch. The FIFO empties via normal pops; when it is empty → HALTED.
  - HALTED: halted=1. start → RUN (same actions as from IDLE). redirect ignored.
- imem_addr = pc in all states (combinational from the register).
- Pop: occurs when out_valid & out_ready. The FIFO supports enqueue and pop in the same cycle at any occupancy.
- Redirect:
  - Valid in RUN or DRAIN; redirect_valid has priority over enqueue and halt detection that cycle.
  - On a redirect: FIFO flushed (any same-cycle pop still counts as consumed), pc=redirect_addr&16'hFFFE, fault cleared, state=RUN.
  - No enqueue in the redirect cycle. The first post-redirect instruction is enqueued the next cycle.
  - A redirect during DRAIN cancels the halt, because the sentinel was fetched speculatively past the branch.
- Latency: start sampled in cycle N → imem_addr=RESET_PC in N+1 → out_valid=1 in N+2. Redirect has the same two-cycle bubble.
- With out_ready held high, throughput is 1 instruction per cycle.
- PC arithmetic: 16-bit, wraps modulo 2^16. The range check catches the wrap for MEM_WORDS < 32768.
- start while in RUN or DRAIN: ignored.
- Reset mid-operation: all state discarded; the next cycle is IDLE with outputs at their reset values.

Decomposition:
- Shared package fetch_pkg:
  - state enum {IDLE, RUN, DRAIN, HALTED}.
  - HALT_WORD default constant.
  - INSTR_W=16, ADDR_W=16.
- Sub-module fetch_fifo: 2-entry FIFO of {pc[15:0], instr[15:0]}.
  - Ports: push, pop, flush, full, empty, head data.
  - Supports simultaneous push/pop.
- Top module: FSM, PC register, counter.

Test Plan:
- Sequential fetch: memory words 0..9 = 16'h710F, 16'h7207, 16'h26C0, ... with word 9 = 16'hFFFF; pulse start, out_ready=1.
  - Expect 9 instructions at out_pc 0x0000..0x0010 in order, the first at cycle N+2.
  - Expect no 16'hFFFF output, halted=1 one cycle after the last pop, fetch_count=9.
- Backpressure: out_ready=0 for 5 cycles after start.
  - out_instr/out_pc hold at 16'h710F/0x0000.
  - imem_addr stops at 0x0004 (FIFO full with 2 entries).
  - After release, all instructions arrive in order with no loss or duplication.
- Redirect: redirect_valid=1, redirect_addr=16'h000D while the FIFO holds 2 entries.
  - FIFO empties next cycle; imem_addr=0x000C; next out_pc=0x000C.
- Halt cancel: sentinel at word 3, redirect to 0x0000 asserted while in DRAIN.
  - state returns to RUN, halted never asserts, fetch restarts at 0x0000.
- Out-of-range: MEM_WORDS=4, no sentinel.
  - 4 instructions output; fault=1 and halted=1 after pc reaches 0x0008.
  - A start pulse clears fault and refetches from 0x0000.
- Reset mid-run: assert reset with 2 entries buffered.
  - Next cycle out_valid=0, halted=0, fetch_count=0, imem_addr=RESET_PC; no fetch until start.
